// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_pkg
// Purpose  : Shared geometry constants and types for the LED matrix scanner.
// Revision : 1.0  initial release
// ============================================================================
package led_matrix_pkg;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;
    localparam int IDX_W    = 3;
    localparam int PRESC_W  = 16;

    typedef logic [IDX_W-1:0] col_idx_t;

endpackage
`default_nettype wire

// File: rtl/contador.sv
`default_nettype none
// ============================================================================
// Module   : contador
// Purpose  : Free-running prescaler plus 0..4 column index.
// Revision : 1.0  initial release
// ============================================================================
module contador
    import led_matrix_pkg::*;
#(
    parameter int SCAN_DIV = 1
)(
    input  logic     clk,
    input  logic     rst_n,
    output col_idx_t o_idx
);

    localparam logic [PRESC_W-1:0] c_PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] c_PRESC_ONE = 1;
    localparam col_idx_t           c_LAST_COL  = col_idx_t'(NUM_COLS - 1);
    localparam col_idx_t           c_IDX_ONE   = 1;

    logic [PRESC_W-1:0] r_presc;
    col_idx_t           r_idx;
    logic               w_tick;
    col_idx_t           w_idx_next;

    assign w_tick = (r_presc == c_PRESC_MAX);

    // Anything at or past the last column (including upset values 5..7) recovers to 0.
    assign w_idx_next = (r_idx >= c_LAST_COL) ? '0 : r_idx + c_IDX_ONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PRESC_ONE;
            if (w_tick) begin
                r_idx <= w_idx_next;
            end
        end
    end

    assign o_idx = r_idx;

endmodule
`default_nettype wire

// File: rtl/demux_1x5.sv
`default_nettype none
// ============================================================================
// Module   : demux_1x5
// Purpose  : Column index plus enable to one-hot active-high column drives.
// Revision : 1.0  initial release
// ============================================================================
module demux_1x5
    import led_matrix_pkg::*;
(
    input  logic                i_en,
    input  col_idx_t            i_idx,
    output logic [NUM_COLS-1:0] o_cols
);

    always_comb begin
        o_cols = '0;
        if (i_en) begin
            case (i_idx)
                3'd0:    o_cols[0] = 1'b1;
                3'd1:    o_cols[1] = 1'b1;
                3'd2:    o_cols[2] = 1'b1;
                3'd3:    o_cols[3] = 1'b1;
                3'd4:    o_cols[4] = 1'b1;
                default: o_cols    = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_5x1.sv
`default_nettype none
// ============================================================================
// Module   : mux_5x1
// Purpose  : Selects one column's bitmap bit for a row; 0 for invalid index.
// Revision : 1.0  initial release
// ============================================================================
module mux_5x1
    import led_matrix_pkg::*;
(
    input  logic [NUM_COLS-1:0] i_bits,
    input  col_idx_t            i_sel,
    output logic                o_bit
);

    always_comb begin
        o_bit = 1'b0;
        case (i_sel)
            3'd0:    o_bit = i_bits[0];
            3'd1:    o_bit = i_bits[1];
            3'd2:    o_bit = i_bits[2];
            3'd3:    o_bit = i_bits[3];
            3'd4:    o_bit = i_bits[4];
            default: o_bit = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/led_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : led_matrix_scan
// Purpose  : 5x7 LED matrix column scanner with active-low row drives.
// Revision : 1.0  initial release
// ============================================================================
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int SCAN_DIV = 1
)(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [6:0] mapa0,
    input  logic [6:0] mapa1,
    input  logic [6:0] mapa2,
    input  logic [6:0] mapa3,
    input  logic [6:0] mapa4,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       l0,
    output logic       l1,
    output logic       l2,
    output logic       l3,
    output logic       l4,
    output logic       l5,
    output logic       l6
);

    col_idx_t            w_idx;
    logic [NUM_COLS-1:0] w_cols;
    logic [NUM_ROWS-1:0] w_row_sel;
    logic [NUM_ROWS-1:0] w_rows_n;

    contador #(
        .SCAN_DIV (SCAN_DIV)
    ) u_contador (
        .clk   (clock),
        .rst_n (reset_n),
        .o_idx (w_idx)
    );

    demux_1x5 u_demux (
        .i_en   (enable),
        .i_idx  (w_idx),
        .o_cols (w_cols)
    );

    // Row i takes bit (6-i) of every column bitmap; bit 6 is the top row.
    generate
        for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
            logic [NUM_COLS-1:0] w_bits;
            assign w_bits = {mapa4[NUM_ROWS-1-i], mapa3[NUM_ROWS-1-i],
                             mapa2[NUM_ROWS-1-i], mapa1[NUM_ROWS-1-i],
                             mapa0[NUM_ROWS-1-i]};
            mux_5x1 u_mux (
                .i_bits (w_bits),
                .i_sel  (w_idx),
                .o_bit  (w_row_sel[i])
            );
            assign w_rows_n[i] = enable ? ~w_row_sel[i] : 1'b1;
        end
    endgenerate

    assign {c0, c1, c2, c3, c4} = {w_cols[0], w_cols[1], w_cols[2], w_cols[3], w_cols[4]};
    assign {l0, l1, l2, l3, l4, l5, l6} = {w_rows_n[0], w_rows_n[1], w_rows_n[2], w_rows_n[3],
                                           w_rows_n[4], w_rows_n[5], w_rows_n[6]};

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_matrix_scan
// Purpose  : Self-checking bench for led_matrix_scan (SCAN_DIV 1 and 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_led_matrix_scan;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic [6:0] mapa [5];
    logic [4:0] cols1, cols4;   // {c0..c4}
    logic [6:0] rows1, rows4;   // {l0..l6}

    int total = 0;
    int bad   = 0;
    int n     = 0;              // cycles since the last reset edge
    bit valid = 1'b0;

    logic [6:0] rows_lit [5] = '{7'b1111011, 7'b1110011, 7'b0111010, 7'b0001110, 7'b0111100};

    always #5 clk = ~clk;

    led_matrix_scan #(.SCAN_DIV(1)) dut1 (
        .clock(clk), .reset_n(reset_n), .enable(enable),
        .mapa0(mapa[0]), .mapa1(mapa[1]), .mapa2(mapa[2]), .mapa3(mapa[3]), .mapa4(mapa[4]),
        .c0(cols1[4]), .c1(cols1[3]), .c2(cols1[2]), .c3(cols1[1]), .c4(cols1[0]),
        .l0(rows1[6]), .l1(rows1[5]), .l2(rows1[4]), .l3(rows1[3]),
        .l4(rows1[2]), .l5(rows1[1]), .l6(rows1[0])
    );

    led_matrix_scan #(.SCAN_DIV(4)) dut4 (
        .clock(clk), .reset_n(reset_n), .enable(enable),
        .mapa0(mapa[0]), .mapa1(mapa[1]), .mapa2(mapa[2]), .mapa3(mapa[3]), .mapa4(mapa[4]),
        .c0(cols4[4]), .c1(cols4[3]), .c2(cols4[2]), .c3(cols4[1]), .c4(cols4[0]),
        .l0(rows4[6]), .l1(rows4[5]), .l2(rows4[4]), .l3(rows4[3]),
        .l4(rows4[2]), .l5(rows4[1]), .l6(rows4[0])
    );

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%b expected=%b", name, $time, got, exp);
        end
    endtask

    // Column shown is simply (cycles since reset / SCAN_DIV) mod 5.
    function automatic logic [11:0] exp_out(input int cyc, input int div);
        int k;
        logic [4:0] c;
        k = (cyc / div) % 5;
        c = 5'b10000 >> k;
        if (!enable) return {5'b00000, 7'h7f};
        return {c, ~mapa[k]};
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            n     <= 0;
            valid <= 1'b1;
        end else begin
            n <= n + 1;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            chk("model_div1", {cols1, rows1}, exp_out(n, 1));
            chk("model_div4", {cols4, rows4}, exp_out(n, 4));
            chk("onehot_div1", 12'($countones(cols1) <= 1), 12'd1);
            chk("onehot_div4", 12'($countones(cols4) <= 1), 12'd1);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mapa[0] = 7'b0000100;
        mapa[1] = 7'b0001100;
        mapa[2] = 7'b1000101;
        mapa[3] = 7'b1110001;
        mapa[4] = 7'b1000011;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;                       // cycle 0

        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            chk("scan_cols", 12'(cols1), 12'(5'b10000 >> (c % 5)));
            chk("scan_rows", 12'(rows1), 12'(rows_lit[c % 5]));
            case (c)
                3:  chk("div4_hold_c3",  12'(cols4), 12'b10000);
                4:  chk("div4_adv_c4",   12'(cols4), 12'b01000);
                19: chk("div4_last_c19", 12'(cols4), 12'b00001);
                20: chk("div4_wrap_c20", 12'(cols4), 12'b10000);
                default: ;
            endcase
            next_cycle();
        end

        next_cycle();                            // cycle 22, column 2
        enable = 1'b0;
        @(negedge clk);
        chk("disable_dark", {cols1, rows1}, {5'b00000, 7'b1111111});
        next_cycle();
        @(negedge clk);
        chk("disable_dark23", {cols1, rows1}, {5'b00000, 7'b1111111});
        next_cycle();
        @(negedge clk);
        chk("disable_dark24", {cols1, rows1}, {5'b00000, 7'b1111111});
        next_cycle();                            // cycle 25
        enable = 1'b1;
        @(negedge clk);
        chk("reenable_col0", {cols1, rows1}, {5'b10000, 7'b1111011});

        next_cycle();
        next_cycle();                            // cycle 27, column 2
        @(negedge clk);
        chk("col2_before", {cols1, rows1}, {5'b00100, 7'b0111010});
        #1 mapa[2] = 7'b0000000;
        #1 chk("mapa_live", {cols1, rows1}, {5'b00100, 7'b1111111});
        next_cycle();                            // cycle 28, column 3
        mapa[2] = 7'b1000101;
        reset_n = 1'b0;
        @(negedge clk);
        chk("pre_reset_col3", 12'(cols1), 12'b00010);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_col0", {cols1, rows1}, {5'b10000, 7'b1111011});
        chk("reset_col0_div4", 12'(cols4), 12'b10000);
        next_cycle();
        @(negedge clk);
        chk("post_reset_col1", {cols1, rows1}, {5'b01000, 7'b1110011});

        for (int i = 0; i < 40; i++) begin
            next_cycle();
            for (int j = 0; j < 5; j++) mapa[j] = 7'($urandom);
            enable  = ($urandom_range(0, 3) != 0);
            reset_n = (i != 20);
        end
        next_cycle();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
